// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared types and constants for the multicycle control sequencer.
// Revision : 1.0
// ============================================================================
package mc_pkg;

    typedef enum logic [2:0] {
        IC_ALU     = 3'd0,
        IC_LOAD    = 3'd1,
        IC_STORE   = 3'd2,
        IC_BRANCH  = 3'd3,
        IC_JUMP    = 3'd4,
        IC_MULDIV  = 3'd5,
        IC_ILLEGAL = 3'd7
    } iclass_t;

    typedef enum logic [2:0] {
        ST_RST_IDLE = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MD_WAIT  = 3'd4,
        ST_MEM      = 3'd5,
        ST_WB       = 3'd6
    } state_t;

    localparam logic [1:0]  PCSRC_PC4 = 2'd0;
    localparam logic [1:0]  PCSRC_BR  = 2'd1;
    localparam logic [1:0]  PCSRC_J   = 2'd2;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;

    // Encoding 6 (and anything else unlisted) decodes as ILLEGAL.
    function automatic iclass_t decode_class(input logic [2:0] code);
        case (code)
            3'd0:    return IC_ALU;
            3'd1:    return IC_LOAD;
            3'd2:    return IC_STORE;
            3'd3:    return IC_BRANCH;
            3'd4:    return IC_JUMP;
            3'd5:    return IC_MULDIV;
            default: return IC_ILLEGAL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_if
// Brief    : Decoder/datapath-facing signal bundle of the control sequencer.
// Revision : 1.0
// ============================================================================
interface mc_ctrl_if;
    logic [2:0]  iclass;
    logic        br_taken;
    logic        md_busy;
    logic        pc_write;
    logic        pc_read;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        ab_write;
    logic        aluout_write;
    logic        rf_write;
    logic        mem_read;
    logic        mem_write;
    logic        md_start;
    logic        md_err;
    logic        ill_instr;
    logic [31:0] retired;
    logic [2:0]  state;

    modport slave (
        input  iclass, br_taken, md_busy,
        output pc_write, pc_read, pc_src, ir_write, ab_write, aluout_write,
               rf_write, mem_read, mem_write, md_start, md_err, ill_instr,
               retired, state
    );

    modport master (
        output iclass, br_taken, md_busy,
        input  pc_write, pc_read, pc_src, ir_write, ab_write, aluout_write,
               rf_write, mem_read, mem_write, md_start, md_err, ill_instr,
               retired, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_out.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_out
// Brief    : Combinational state/class to strobe decoder, incl. retire event.
// Revision : 1.0
// ============================================================================
module mc_ctrl_out
    import mc_pkg::*;
(
    input  var state_t    i_state,
    input  var iclass_t   i_class,
    input  wire logic     i_br_taken,
    input  wire logic     i_md_busy,
    input  wire logic     i_md_last,
    output logic          o_pc_write,
    output logic          o_pc_read,
    output logic [1:0]    o_pc_src,
    output logic          o_ir_write,
    output logic          o_ab_write,
    output logic          o_aluout_write,
    output logic          o_rf_write,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic          o_md_start,
    output logic          o_md_err,
    output logic          o_ill_instr,
    output logic          o_retire
);

    always_comb begin
        o_pc_write     = 1'b0;
        o_pc_read      = (i_state != ST_RST_IDLE);
        o_pc_src       = PCSRC_PC4;
        o_ir_write     = 1'b0;
        o_ab_write     = 1'b0;
        o_aluout_write = 1'b0;
        o_rf_write     = 1'b0;
        o_mem_read     = 1'b0;
        o_mem_write    = 1'b0;
        o_md_start     = 1'b0;
        o_md_err       = 1'b0;
        o_ill_instr    = 1'b0;
        o_retire       = 1'b0;
        case (i_state)
            ST_FETCH: begin
                o_mem_read = 1'b1;
                o_ir_write = 1'b1;
                o_pc_write = 1'b1;
            end
            ST_DECODE: begin
                o_ab_write = 1'b1;
                if (i_class == IC_JUMP) begin
                    o_pc_write = 1'b1;
                    o_pc_src   = PCSRC_J;
                    o_retire   = 1'b1;
                end else if (i_class == IC_ILLEGAL) begin
                    o_ill_instr = 1'b1;
                    o_retire    = 1'b1;
                end
            end
            ST_EXEC: begin
                o_aluout_write = 1'b1;
                if (i_class == IC_BRANCH) begin
                    o_pc_write = i_br_taken;
                    o_pc_src   = PCSRC_BR;
                    o_retire   = 1'b1;
                end else if (i_class == IC_MULDIV) begin
                    o_md_start = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                // A busy drop on the last allowed cycle is a normal completion.
                if (!i_md_busy) begin
                    o_retire = 1'b1;
                end else if (i_md_last) begin
                    o_md_err = 1'b1;
                    o_retire = 1'b1;
                end
            end
            ST_MEM: begin
                if (i_class == IC_LOAD) begin
                    o_mem_read = 1'b1;
                end else begin
                    o_mem_write = 1'b1;
                    o_retire    = 1'b1;
                end
            end
            ST_WB: begin
                o_rf_write = 1'b1;
                o_retire   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multicycle MIPS control sequencer: state, timeout and retire regs.
// Revision : 1.0
// ============================================================================
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    mc_ctrl_if.slave  bus
);

    localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] c_md_last = CW'(MD_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_md_cnt;
    logic [31:0]     r_retired;
    iclass_t         w_class;
    logic            w_md_last;
    logic            w_retire;

    assign w_class   = decode_class(bus.iclass);
    assign w_md_last = (r_md_cnt == c_md_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST_IDLE: w_next = ST_FETCH;
            ST_FETCH:    w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_class == IC_JUMP || w_class == IC_ILLEGAL) w_next = ST_FETCH;
                else                                             w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_class)
                    IC_LOAD, IC_STORE: w_next = ST_MEM;
                    IC_ALU:            w_next = ST_WB;
                    IC_MULDIV:         w_next = ST_MD_WAIT;
                    default:           w_next = ST_FETCH;
                endcase
            end
            ST_MD_WAIT: begin
                if (!bus.md_busy || w_md_last) w_next = ST_FETCH;
            end
            ST_MEM: w_next = (w_class == IC_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:  w_next = ST_FETCH;
            default: w_next = ST_RST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_cnt <= '0;
        end else if (r_state == ST_EXEC) begin
            r_md_cnt <= '0;
        end else if (r_state == ST_MD_WAIT && !w_md_last) begin
            r_md_cnt <= r_md_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    mc_ctrl_out u_out (
        .i_state        (r_state),
        .i_class        (w_class),
        .i_br_taken     (bus.br_taken),
        .i_md_busy      (bus.md_busy),
        .i_md_last      (w_md_last),
        .o_pc_write     (bus.pc_write),
        .o_pc_read      (bus.pc_read),
        .o_pc_src       (bus.pc_src),
        .o_ir_write     (bus.ir_write),
        .o_ab_write     (bus.ab_write),
        .o_aluout_write (bus.aluout_write),
        .o_rf_write     (bus.rf_write),
        .o_mem_read     (bus.mem_read),
        .o_mem_write    (bus.mem_write),
        .o_md_start     (bus.md_start),
        .o_md_err       (bus.md_err),
        .o_ill_instr    (bus.ill_instr),
        .o_retire       (w_retire)
    );

    assign bus.retired = r_retired;
    assign bus.state   = r_state;

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control sequencer for the non-pipelined 54-instruction MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the write and read strobes of the PC, IR, A/B, ALUOut and register-file registers, plus memory and mul/div unit handshakes. It sits directly upstream of the PC and datapath register bank: every `Write`/`Read` enable on those registers originates here.

## Interface

- `MD_TIMEOUT`, default 64: maximum cycles in MD_WAIT before forced abort.
- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `iclass` in 3: instruction class from decoder, valid from DECODE onward; encoding in package.
- `br_taken` in 1: branch condition from ALU compare, sampled in EXEC.
- `md_busy` in 1: mul/div unit busy.
- `pc_write`, `pc_read` out 1: PC register enables.
- `pc_src` out 2: PC input mux select: 0 PC+4, 1 branch target, 2 jump target.
- `ir_write`, `ab_write`, `aluout_write`, `rf_write` out 1: datapath register write strobes.
- `mem_read`, `mem_write` out 1: memory strobes.
- `md_start` out 1: one-cycle mul/div start pulse.
- `md_err` out 1: pulse on MD_WAIT timeout.
- `ill_instr` out 1: pulse on ILLEGAL class in DECODE.
- `retired` out 32: retired-instruction counter.
- `state` out 3: current state, debug.

## Operation

- States: RST_IDLE, FETCH, DECODE, EXEC, MD_WAIT, MEM, WB.
- Classes: ALU (R and I), LOAD, STORE, BRANCH, JUMP, MULDIV, ILLEGAL.
- RST_IDLE: all strobes 0; next FETCH.
- FETCH: `mem_read`, `ir_write`, `pc_write`, `pc_src`=0; next DECODE.
- DECODE: `ab_write`.
  - JUMP: `pc_write`, `pc_src`=2, retire, next FETCH.
  - ILLEGAL: `ill_instr`, retire, next FETCH.
  - Otherwise: next EXEC.
- EXEC: `aluout_write`.
  - BRANCH: `pc_write`=`br_taken`, `pc_src`=1, retire, next FETCH.
  - LOAD/STORE: next MEM.
  - ALU: next WB.
  - MULDIV: `md_start`, clear timeout counter, next MD_WAIT.
- MD_WAIT: count cycles.
  - `md_busy`=0: retire, next FETCH.
  - Count reaches MD_TIMEOUT-1 with `md_busy`=1: `md_err`, retire, next FETCH.
  - If `md_busy` falls on the timeout cycle, the exit is normal and `md_err` stays 0.
- MEM:
  - LOAD: `mem_read`, next WB.
  - STORE: `mem_write`, retire, next FETCH.
- WB: `rf_write`, retire, next FETCH.
- `pc_read` is 1 in every state except RST_IDLE.
- `retired` increments by 1 on each retire event and wraps from 0xFFFF_FFFF to 0.
- Unused `iclass` encodings are treated as ILLEGAL.

## Timing

- Strobes are combinational from the registered state, plus `br_taken` in EXEC. All are valid within the cycle and sampled by the registers on the same rising edge.
- Reset (`rst`=0), asynchronous: state←RST_IDLE, `retired`←0, timeout counter←0. All strobes are 0, `pc_src`=0, `state`=RST_IDLE.
- First FETCH occurs on the second rising edge after `rst` deasserts. The PC register therefore holds 0x0040_0000 when first read.
- CPI, counting the FETCH cycle:
  - JUMP/ILLEGAL 2.
  - BRANCH 3.
  - ALU/STORE 4.
  - LOAD 5.
  - MULDIV 3 + N, where N is the number of MD_WAIT cycles: minimum 1, maximum MD_TIMEOUT.
- `md_start` is high exactly one cycle and never while in MD_WAIT.
- Reset mid-instruction aborts it. No retire is counted and no strobe is issued after `rst` falls.
- At most one retire per cycle. `ill_instr`/`md_err` are one-cycle pulses.

## Structure

- Package `mc_pkg`:
  - `iclass_t` encoding: ALU=0, LOAD=1, STORE=2, BRANCH=3, JUMP=4, MULDIV=5, ILLEGAL=7.
  - `state_t` encoding.
  - `pc_src` constants: PCSRC_PC4, PCSRC_BR, PCSRC_J.
  - Reset PC constant 0x0040_0000, shared with the PC register.
- Sub-module `mc_ctrl_out`: combinational state/class → strobe decoder. The top holds the state register, timeout counter and `retired` counter.

## Test plan

- Reset release, ALU class held: states RST_IDLE→FETCH→DECODE→EXEC→WB→FETCH. `rf_write` is 1 only in WB; `retired`=1 after the WB edge.
- LOAD then STORE: `mem_read` in FETCH and MEM. `mem_write` only in the STORE MEM cycle. Cycle counts 5 and 4; `retired`=2.
- BRANCH with `br_taken`=1, then 0: EXEC `pc_write`=1 with `pc_src`=1, then `pc_write`=0. Both return to FETCH after 3 cycles.
- MULDIV, `md_busy` high 5 cycles: single `md_start` pulse, 5 MD_WAIT cycles, exit with `md_err`=0. Repeat with `md_busy` stuck high and MD_TIMEOUT=64: `md_err` pulses on the 64th MD_WAIT cycle, then FETCH.
- `iclass`=6 in DECODE: `ill_instr` pulse, next FETCH, `retired` increments. JUMP: `pc_src`=2 with `pc_write` in DECODE, 2-cycle CPI.
- `rst` low mid-MEM of a STORE: no `mem_write` after the falling edge, `retired` reads 0 and state reads RST_IDLE immediately. Preset `retired` to 0xFFFF_FFFF via force, retire once: reads 0.
